// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the bit-counter width helper.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Counter must hold 0..width inclusive without wrapping.
  function automatic int cnt_bits(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - b_in, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  assign d     = a ^ b ^ b_in;
  assign b_out = (~a & b) | (~(a ^ b) & b_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with a
// one-cycle done pulse carrying the WIDTH-bit difference and final borrow.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             borrow_out
);

  localparam int CW = cnt_bits(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             br_q;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] z_q;
  logic             bout_q;

  logic             diff_s;
  logic             br_d;
  logic [WIDTH-1:0] r_d;
  logic             last_bit_s;

  full_subtractor u_fs (
    .a     (a_q[0]),
    .b     (b_q[0]),
    .b_in  (br_q),
    .d     (diff_s),
    .b_out (br_d)
  );

  assign r_d        = {diff_s, r_q[WIDTH-1:1]};
  assign last_bit_s = (cnt_q == CW'(WIDTH - 1));

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= x;
            b_q     <= y;
            br_q    <= borrow_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          br_q  <= br_d;
          r_q   <= r_d;
          cnt_q <= cnt_q + CW'(1);
          // The last bit's result goes straight into z, so z is never partial.
          if (last_bit_s) begin
            z_q     <= r_d;
            bout_q  <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= RUN;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign z          = z_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): expected results are
// queued at launch and compared on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] z;
  logic         borrow_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x          (x),
    .y          (y),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .z          (z),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: {borrow, difference}.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    int diff;
    logic [W-1:0] zz;
    logic bo;
    diff = int'(a) - int'(b) - int'(bi);
    zz = diff[W-1:0];
    bo = (int'(a) < int'(b) + int'(bi));
    return {bo, zz};
  endfunction

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("z", 32'(z), 32'(e[W-1:0]));
        check_val("borrow_out", 32'(borrow_out), 32'(e[W]));
      end
    end
  end

  // Drive one start pulse; caller guarantees the sampling edge is in IDLE or DONE.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    x = a;
    y = b;
    borrow_in = bi;
    start = 1'b1;
    exp_q.push_back(model(a, b, bi));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; optionally inject a stray start at cycle glitch_at.
  task automatic wait_done(input int glitch_at);
    int  cycles;
    int  busy_cnt;
    bit  seen;
    cycles = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      if (cycles == glitch_at) begin
        start = 1'b1;
        x = 8'd1;
        y = 8'd1;
        borrow_in = 1'b0;
      end else if (cycles == glitch_at + 1) begin
        start = 1'b0;
      end
    end
    check_val("latency", 32'(cycles), 32'(W + 1));
    check_val("busy_cycles", 32'(busy_cnt), 32'(W));
  endtask

  initial begin
    int dones;
    rst = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_z", 32'(z), 32'd0);
    check_val("rst_bout", 32'(borrow_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    launch(8'd200, 8'd55, 1'b0);
    wait_done(0);
    launch(8'd5, 8'd10, 1'b0);
    wait_done(0);
    launch(8'd0, 8'd0, 1'b1);
    wait_done(0);
    launch(8'd255, 8'd255, 1'b1);
    wait_done(0);

    // Stray start during RUN, then start held in DONE for a gapless second op.
    launch(8'd200, 8'd55, 1'b0);
    wait_done(3);
    launch(8'd7, 8'd3, 1'b1);
    check_val("no_gap_busy", 32'(busy), 32'd1);
    wait_done(0);
    check_val("hold_z", 32'(z), 32'd3);
    @(negedge clk);
    check_val("hold_z_idle", 32'(z), 32'd3);
    check_val("idle_busy", 32'(busy), 32'd0);

    // Reset mid-run aborts with no done pulse.
    launch(8'd200, 8'd55, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    check_val("abort_z", 32'(z), 32'd0);
    check_val("abort_bout", 32'(borrow_out), 32'd0);
    exp_q.delete();
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("abort_no_done", 32'(dones), 32'd0);

    // Random operations.
    for (int i = 0; i < 1000; i++) begin
      launch(W'($urandom_range(255, 0)), W'($urandom_range(255, 0)), 1'($urandom_range(1, 0)));
      wait_done(0);
    end

    @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand and result width in bits (legal values 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, reset; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, request to load operands and begin subtraction.
REQ-005 The block SHALL have port x, input, WIDTH bits, minuend (unsigned).
REQ-006 The block SHALL have port y, input, WIDTH bits, subtrahend (unsigned).
REQ-007 The block SHALL have port borrow_in, input, 1 bit, incoming borrow.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, single-cycle pulse marking a valid result.
REQ-010 The block SHALL have port z, output, WIDTH bits, difference.
REQ-011 The block SHALL have port borrow_out, output, 1 bit, outgoing borrow.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 In IDLE or DONE, a start sampled high SHALL capture x, y and borrow_in into internal registers, clear the bit counter, and enter RUN; x, y and borrow_in are otherwise don't-care.
REQ-014 In RUN, each cycle SHALL process one bit, LSB first: d = a0 ^ b0 ^ br; br_next = (~a0 & b0) | (~(a0 ^ b0) & br); d is shifted into the result register from the MSB side, and the operand registers shift right.
REQ-015 After exactly WIDTH RUN cycles, the FSM SHALL enter DONE; DONE SHALL last one cycle, then return to IDLE unless start is high.
REQ-016 done SHALL be high exactly during the DONE cycle, i.e. WIDTH+1 rising edges after the edge that sampled start.
REQ-017 busy SHALL be high exactly while in RUN.
REQ-018 At done, z SHALL equal (x - y - borrow_in) mod 2^WIDTH, and borrow_out SHALL be 1 iff x < y + borrow_in.
REQ-019 z and borrow_out SHALL hold their last result until the next DONE; they are not valid during RUN.
REQ-020 start SHALL be ignored while in RUN; the in-flight operation SHALL NOT be disturbed.
REQ-021 start high in DONE SHALL be accepted, so back-to-back operations run with no idle cycle.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-023 With rst high at a clock edge, the FSM SHALL go to IDLE, and busy, done, z, borrow_out and all internal registers SHALL go to 0; rst SHALL take priority over start.
REQ-024 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow for that operation.

Structure
REQ-025 The state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL reside in a shared package/include serial_subtractor_pkg.
REQ-026 The per-bit logic SHALL be one combinational sub-module, full_subtractor (ports a, b, b_in, d, b_out), instantiated once.

Verification (WIDTH=8)
REQ-027 x=200, y=55, borrow_in=0, start pulsed -> busy for 8 cycles; done at edge 9; z=145, borrow_out=0.
REQ-028 x=5, y=10, borrow_in=0 -> z=251, borrow_out=1.
REQ-029 x=0, y=0, borrow_in=1 -> z=255, borrow_out=1; also x=255, y=255, borrow_in=1 -> z=255, borrow_out=1.
REQ-030 Second start with x=1, y=1 issued 3 cycles into a 200-55 run -> ignored; result 145; start held in DONE -> next op begins with no gap.
REQ-031 rst asserted 4 cycles into a run -> next cycle IDLE, all outputs 0, no done pulse.
REQ-032 A bench SHALL run 1000 random x, y and borrow_in operations ($urandom_range) -> every z and borrow_out matches the REQ-018 arithmetic model.
